// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked EX-stage ALU. Single-cycle ops register their
// result on the accept edge; mult/multu/div/divu run WIDTH shift-add or
// restoring-subtract iterations, the first one on the accept edge itself.
//
// Handshake: an op is accepted on a rising edge where InValid & InReady.
// InReady is high in IDLE, or in DONE while OutReady is high (retire and
// accept on the same edge). A result is offered while OutValid is high and
// retires on an edge where OutReady is high; outputs hold while it waits.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic [1:0]       DbgState
);

  localparam int SHW = $clog2(WIDTH);
  // Iterations still to run after the one done on the accept edge.
  localparam logic [SHW-1:0] ITER_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, a_raw_q;
  logic             neg_lo_q, neg_hi_q, dbz_pend_q;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             ovf_q, dbz_q;

  logic             accept, in_compute, last_iter;
  logic             is_multi, is_div_in, is_signed_in, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] alu_lo, sum, diff;
  logic             alu_ovf;
  logic             it_div;
  logic [WIDTH-1:0] it_hi, it_lo, it_m, nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum, r_sh, r_sub;
  logic [2*WIDTH-1:0] prod_mag, prod_fin;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign in_compute = (state_q == S_COMPUTE);
  assign last_iter  = in_compute && (cnt_q == SHW'(1));
  assign InReady    = (state_q == S_IDLE) || ((state_q == S_DONE) && OutReady);
  assign accept     = InValid && InReady;
  assign OutValid   = (state_q == S_DONE);
  assign ALUResult   = res_q;
  assign ALUResultHi = res_hi_q;
  assign Overflow    = ovf_q;
  assign DivByZero   = dbz_q;
  assign Zero        = (res_q == '0);
  assign DbgState    = state_q;

  // Decode of the incoming op and magnitudes for the signed mul/div forms.
  always_comb begin
    is_multi     = (ALUControl >= 4'd11) && (ALUControl <= 4'd14);
    is_div_in    = (ALUControl == 4'd13) || (ALUControl == 4'd14);
    is_signed_in = (ALUControl == 4'd11) || (ALUControl == 4'd13);
    sgn_a        = is_signed_in && A[WIDTH-1];
    sgn_b        = is_signed_in && B[WIDTH-1];
    mag_a        = sgn_a ? -A : A;
    mag_b        = sgn_b ? -B : B;
  end

  // Single-cycle result and add/sub signed overflow.
  always_comb begin
    alu_lo  = '0;
    alu_ovf = 1'b0;
    sum     = A + B;
    diff    = A - B;
    case (ALUControl)
      4'd0: begin
        alu_lo  = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        alu_lo  = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2:    alu_lo = A & B;
      4'd3:    alu_lo = A | B;
      4'd4:    alu_lo = ~(A | B);
      4'd5:    alu_lo = A ^ B;
      4'd6:    alu_lo = A << B[SHW-1:0];
      4'd7:    alu_lo = A >> B[SHW-1:0];
      4'd8:    alu_lo = $signed(A) >>> B[SHW-1:0];
      4'd9:    alu_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd10:   alu_lo = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_lo = '0;
    endcase
  end

  // One mul/div iteration. On the accept edge it starts from fresh
  // operands; afterwards from the accumulator registers.
  // mul: lo holds the multiplier, shifted out LSB first; hi accumulates.
  // div: lo holds the dividend shifting into hi (remainder), quotient
  //      bits shift into lo from the bottom.
  always_comb begin
    it_div = in_compute ? ((op_q == 4'd13) || (op_q == 4'd14)) : is_div_in;
    it_hi  = in_compute ? acc_hi_q : '0;
    it_lo  = in_compute ? acc_lo_q : (is_div_in ? mag_a : mag_b);
    it_m   = in_compute ? opnd_q   : (is_div_in ? mag_b : mag_a);
    mul_sum = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_m} : '0);
    r_sh    = {it_hi, it_lo[WIDTH-1]};
    r_sub   = r_sh - {1'b0, it_m};
    if (it_div) begin
      if (!r_sub[WIDTH]) begin
        nxt_hi = r_sub[WIDTH-1:0];
        nxt_lo = {it_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = r_sh[WIDTH-1:0];
        nxt_lo = {it_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], it_lo[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero override applied on the last iteration.
  always_comb begin
    prod_mag = {nxt_hi, nxt_lo};
    prod_fin = neg_lo_q ? -prod_mag : prod_mag;
    if ((op_q == 4'd13) || (op_q == 4'd14)) begin
      if (dbz_pend_q) begin
        fin_lo = '1;
        fin_hi = a_raw_q;
      end else begin
        fin_lo = neg_lo_q ? -nxt_lo : nxt_lo;
        fin_hi = neg_hi_q ? -nxt_hi : nxt_hi;
      end
    end else begin
      fin_lo = prod_fin[WIDTH-1:0];
      fin_hi = prod_fin[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic for IDLE/COMPUTE/DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_multi ? S_COMPUTE : S_DONE;
      end
      S_COMPUTE: begin
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept)        state_d = is_multi ? S_COMPUTE : S_DONE;
        else if (OutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: operand capture, iteration accumulators and result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      res_q      <= '0;
      res_hi_q   <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else if (accept) begin
      op_q <= ALUControl;
      if (is_multi) begin
        cnt_q      <= ITER_LAST;
        acc_hi_q   <= nxt_hi;
        acc_lo_q   <= nxt_lo;
        opnd_q     <= is_div_in ? mag_b : mag_a;
        a_raw_q    <= A;
        neg_lo_q   <= sgn_a ^ sgn_b;
        neg_hi_q   <= sgn_a;
        dbz_pend_q <= is_div_in && (B == '0);
      end else begin
        res_q    <= alu_lo;
        res_hi_q <= '0;
        ovf_q    <= alu_ovf;
        dbz_q    <= 1'b0;
      end
    end else if (in_compute) begin
      cnt_q    <= cnt_q - SHW'(1);
      acc_hi_q <= nxt_hi;
      acc_lo_q <= nxt_lo;
      if (last_iter) begin
        res_q    <= fin_lo;
        res_hi_q <= fin_hi;
        ovf_q    <= 1'b0;
        dbz_q    <= dbz_pend_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized and directed stimulus for alu_multicycle with
// an expected-result queue filled at accept time and drained by a monitor
// whenever a result retires (OutValid & OutReady).
module tb_alu_multicycle;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef logic [2*W+2:0] exp_t;  // {zero, dbz, ovf, hi, lo}

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [3:0]   ALUControl = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         OutValid;
  wire          OutReady;
  logic [W-1:0] ALUResult, ALUResultHi;
  logic         Zero, Overflow, DivByZero;
  logic [1:0]   DbgState;

  logic rand_ready   = 1'b0;
  logic forced_ready = 1'b1;
  logic rnd_ready    = 1'b1;
  assign OutReady = rand_ready ? rnd_ready : forced_ready;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_got, mon_exp;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .A(A), .B(B), .OutValid(OutValid),
    .OutReady(OutReady), .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
    .Zero(Zero), .Overflow(Overflow), .DivByZero(DivByZero),
    .DbgState(DbgState)
  );

  // Clock and watchdog.
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Random consumer back-pressure, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: results straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] lo, hi;
    logic         ovf, dbz;
    longint       sa, sb, r;
    logic [63:0]  p;
    lo = '0; hi = '0; ovf = 1'b0; dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin r = sa + sb; lo = a + b; ovf = (r > SMAX) || (r < SMIN); end
      4'd1: begin r = sa - sb; lo = a - b; ovf = (r > SMAX) || (r < SMIN); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = ~(a | b);
      4'd5: lo = a ^ b;
      4'd6: lo = a << b[4:0];
      4'd7: lo = a >> b[4:0];
      4'd8: lo = W'($signed(a) >>> b[4:0]);
      4'd9: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: lo = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin p = 64'(sa * sb); {hi, lo} = p; end
      4'd12: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
      4'd13: begin
        if (b == 0) begin lo = '1; hi = a; dbz = 1'b1; end
        else begin
          p = 64'(sa / sb); lo = p[31:0];
          p = 64'(sa % sb); hi = p[31:0];
        end
      end
      4'd14: begin
        if (b == 0) begin lo = '1; hi = a; dbz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin lo = '0; hi = '0; end
    endcase
    return {(lo == '0), dbz, ovf, hi, lo};
  endfunction

  // Scoreboard monitor: compare each retiring result with the queue head.
  always @(negedge Clk) begin
    if (Rst_n && OutValid && OutReady) begin
      mon_got = {Zero, DivByZero, Overflow, ALUResultHi, ALUResult};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected act=%h req=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_result act=%h req=%h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Driver: present an op, hold it until accepted, record its expectation.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
    waited = 0;
    @(negedge Clk);
    ALUControl = op; A = a; B = b; InValid = 1'b1;
    while (!InReady && waited < 300) begin
      @(negedge Clk);
      waited++;
    end
    if (!InReady) begin
      chk("issue_accept_timeout", 80'(InReady), 80'(1));
      InValid = 1'b0;
    end else begin
      exp_q.push_back(model(op, a, b));
      @(posedge Clk);
      #1;
      InValid = 1'b0;
    end
  endtask

  // Cycle 1 = just after the accept edge; counts until OutValid rises.
  task automatic wait_valid(input string name, input int lat);
    int c;
    c = 1;
    while (!OutValid && c < 100) begin
      @(posedge Clk);
      #1;
      c++;
    end
    chk(name, 80'(c), 80'(lat));
  endtask

  initial begin
    int w, n;
    logic [3:0]   op;
    logic [W-1:0] ra, rb;

    // Reset.
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_in_reset", {OutValid, Zero, Overflow, DivByZero, ALUResultHi, ALUResult},
        {1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    chk("reset_released", {OutValid, InReady, Zero, Overflow, DivByZero, ALUResultHi, ALUResult},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});

    // Directed cases with known answers.
    issue(4'd0, 32'h7FFFFFFF, 32'h1, w);
    wait_valid("lat_add", 1);
    chk("add_ovf", {Zero, Overflow, ALUResult}, {1'b0, 1'b1, 32'h80000000});

    issue(4'd11, 32'hFFFFFFFD, 32'd7, w);
    wait_valid("lat_mult", 32);
    chk("mult", {ALUResultHi, ALUResult}, {32'hFFFFFFFF, 32'hFFFFFFEB});

    issue(4'd12, 32'hFFFFFFFD, 32'd7, w);
    wait_valid("lat_multu", 32);
    chk("multu", {ALUResultHi, ALUResult}, {32'h6, 32'hFFFFFFEB});

    issue(4'd13, 32'hFFFFFFF9, 32'd2, w);
    wait_valid("lat_div", 32);
    chk("div_neg", {DivByZero, ALUResultHi, ALUResult}, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});

    issue(4'd14, 32'd7, 32'd0, w);
    wait_valid("lat_divu_zero", 32);
    chk("divu_zero", {DivByZero, ALUResultHi, ALUResult}, {1'b1, 32'h7, 32'hFFFFFFFF});

    issue(4'd13, 32'h80000000, 32'hFFFFFFFF, w);
    wait_valid("lat_div_min", 32);
    chk("div_min_m1", {DivByZero, ALUResultHi, ALUResult}, {1'b0, 32'h0, 32'h80000000});

    issue(4'd8, 32'h80000000, 32'h24, w);
    wait_valid("lat_sra", 1);
    chk("sra", ALUResult, 32'hF8000000);

    issue(4'd15, 32'h12345678, 32'h9ABCDEF0, w);
    wait_valid("lat_rsvd", 1);
    chk("reserved", {Zero, Overflow, DivByZero, ALUResultHi, ALUResult},
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});

    // Hold in DONE under back-pressure, then retire and accept on one edge.
    @(negedge Clk);
    @(negedge Clk);
    forced_ready = 1'b0;
    ra = $urandom; rb = $urandom;
    issue(4'd5, ra, rb, w);
    wait_valid("lat_xor", 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #2;
      chk("stall_hold", {InReady, OutValid, Zero, DivByZero, Overflow, ALUResultHi, ALUResult},
          {1'b0, 1'b1, model(4'd5, ra, rb)});
    end
    forced_ready = 1'b1;
    issue(4'd1, 32'd5, 32'd5, w);
    chk("b2b_accept_wait", 80'(w), 80'(0));
    wait_valid("lat_sub", 1);
    chk("sub_zero", {Zero, Overflow, ALUResult}, {1'b1, 1'b0, 32'h0});

    // Reset in the middle of a divide aborts it.
    issue(4'd0, 32'd1, 32'd2, w);
    wait_valid("lat_add2", 1);
    issue(4'd14, 32'd100, 32'd7, w);
    repeat (9) @(posedge Clk);
    #1;
    chk("abort_busy", 80'(OutValid), 80'(0));
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_reset", {OutValid, Zero, Overflow, DivByZero, ALUResultHi, ALUResult},
        {1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    issue(4'd11, 32'd3, 32'd4, w);
    wait_valid("lat_mult_after_reset", 32);
    chk("mult_after_reset", {ALUResultHi, ALUResult}, {32'h0, 32'd12});

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(0, 40));
        3: ra = 32'($urandom_range(0, 3));
        default: ;
      endcase
      issue(op, ra, rb, w);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge Clk);
      n++;
    end
    chk("drain_empty", 80'(exp_q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
